// File: rtl/cu_fsm_pkg.sv
// cu_fsm_pkg: shared types and constants for the control-unit FSM.
//   state_e    : control-unit state encoding
//   OPCODE_*   : instruction opcode field values (instr[6:0])
//   FUNC_MRET  : func field (instr[14:12]) selecting mret under OPCODE_INTRPT
package cu_fsm_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_e;

    localparam logic [6:0] OPCODE_OP_REG = 7'h33;
    localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
    localparam logic [6:0] OPCODE_LUI    = 7'h37;
    localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
    localparam logic [6:0] OPCODE_JAL    = 7'h6F;
    localparam logic [6:0] OPCODE_JALR   = 7'h67;
    localparam logic [6:0] OPCODE_BRANCH = 7'h63;
    localparam logic [6:0] OPCODE_LOAD   = 7'h03;
    localparam logic [6:0] OPCODE_STORE  = 7'h23;
    localparam logic [6:0] OPCODE_INTRPT = 7'h73;

    localparam logic [2:0] FUNC_MRET = 3'b000;

endpackage

// File: rtl/cu_fsm.sv
// cu_fsm: multicycle control unit. Sequences fetch, execute, load write-back
// and interrupt entry; all strobes are Mealy, decoded from state and inputs.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_INIT  | post-reset cycle, reset_out asserted to PC/datapath
// ST_FETCH | instruction read, waits for imem_ready
// ST_EXEC  | decode/execute; stores wait here for dmem_ready
// ST_WB    | load data wait, register write on dmem_ready
// ST_INTR  | one-cycle interrupt entry (PC <- trap vector)
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   opcode, func            : instr[6:0], instr[14:12]
//   intrpt, csr_mie         : interrupt request level, machine interrupt enable
//   imem_ready, dmem_ready  : instruction / data memory handshakes
//   pc_write .. instr_retire: control strobes to datapath, memories and CSRs
module cu_fsm
    import cu_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func,
    input  logic       intrpt,
    input  logic       csr_mie,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       rf_write,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       mem_we2,
    output logic       csr_we,
    output logic       mret_exec,
    output logic       intrpt_taken,
    output logic       reset_out,
    output logic       instr_retire
);

    state_e state_q;
    state_e state_d;
    logic   retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        pc_write     = 1'b0;
        rf_write     = 1'b0;
        mem_rden1    = 1'b0;
        mem_rden2    = 1'b0;
        mem_we2      = 1'b0;
        csr_we       = 1'b0;
        mret_exec    = 1'b0;
        intrpt_taken = 1'b0;
        reset_out    = 1'b0;

        if (rst) begin
            // Reset overrides every state, including outstanding memory waits.
            reset_out = 1'b1;
            state_d   = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: begin
                    reset_out = 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_FETCH: begin
                    mem_rden1 = 1'b1;
                    if (imem_ready) begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (opcode)
                        OPCODE_OP_REG, OPCODE_OP_IMM, OPCODE_LUI,
                        OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR: begin
                            rf_write = 1'b1;
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                        OPCODE_BRANCH: begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                        OPCODE_LOAD: begin
                            mem_rden2 = 1'b1;
                            state_d   = ST_WB;
                        end
                        OPCODE_STORE: begin
                            mem_we2 = 1'b1;
                            if (dmem_ready) begin
                                pc_write = 1'b1;
                                retire   = 1'b1;
                            end
                        end
                        OPCODE_INTRPT: begin
                            // func[0] (instr bit 12) set selects csrrw.
                            if (func[0]) begin
                                rf_write = 1'b1;
                                csr_we   = 1'b1;
                            end else if (func == FUNC_MRET) begin
                                mret_exec = 1'b1;
                            end
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                        default: begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                        end
                    endcase
                end
                ST_WB: begin
                    mem_rden2 = 1'b1;
                    if (dmem_ready) begin
                        rf_write = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end
                ST_INTR: begin
                    intrpt_taken = 1'b1;
                    pc_write     = 1'b1;
                    state_d      = ST_FETCH;
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase

            // Interrupts are only sampled at instruction boundaries, so a
            // request seen during fetch or a memory wait stays pending.
            if (retire) begin
                state_d = (intrpt && csr_mie) ? ST_INTR : ST_FETCH;
            end
        end
    end

    assign instr_retire = retire;

endmodule

// File: tb/tb_cu_fsm.sv
module tb_cu_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] func;
    logic       intrpt;
    logic       csr_mie;
    logic       imem_ready;
    logic       dmem_ready;
    logic       pc_write, rf_write, mem_rden1, mem_rden2, mem_we2;
    logic       csr_we, mret_exec, intrpt_taken, reset_out, instr_retire;

    cu_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .func         (func),
        .intrpt       (intrpt),
        .csr_mie      (csr_mie),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .rf_write     (rf_write),
        .mem_rden1    (mem_rden1),
        .mem_rden2    (mem_rden2),
        .mem_we2      (mem_we2),
        .csr_we       (csr_we),
        .mret_exec    (mret_exec),
        .intrpt_taken (intrpt_taken),
        .reset_out    (reset_out),
        .instr_retire (instr_retire)
    );

    always #5 clk = ~clk;

    // Strobe bit positions in the packed output vector.
    localparam logic [9:0] PC  = 10'b10_0000_0000;
    localparam logic [9:0] RF  = 10'b01_0000_0000;
    localparam logic [9:0] R1  = 10'b00_1000_0000;
    localparam logic [9:0] R2  = 10'b00_0100_0000;
    localparam logic [9:0] WE  = 10'b00_0010_0000;
    localparam logic [9:0] CSR = 10'b00_0001_0000;
    localparam logic [9:0] MRT = 10'b00_0000_1000;
    localparam logic [9:0] ITK = 10'b00_0000_0100;
    localparam logic [9:0] RO  = 10'b00_0000_0010;
    localparam logic [9:0] RET = 10'b00_0000_0001;

    logic [9:0] outs;
    assign outs = {pc_write, rf_write, mem_rden1, mem_rden2, mem_we2,
                   csr_we, mret_exec, intrpt_taken, reset_out, instr_retire};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%b expected=%b (pc rf r1 r2 we csr mret itk ro ret)",
                     tag, got, exp);
        end
    endtask

    // Inputs are already driven; compare at the falling edge, then advance.
    task automatic cyc(input string tag, input logic [9:0] exp);
        @(negedge clk);
        chk(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_irq();
        return ($urandom_range(0, 2) == 0);
    endfunction

    // Retire cycle: the interrupt decision uses this cycle's intrpt & csr_mie.
    task automatic retire_cycle(input string tag, input logic [9:0] exp);
        logic take;
        intrpt  = rnd_irq();
        csr_mie = $urandom_range(0, 1) == 1;
        take    = intrpt & csr_mie;
        cyc(tag, exp);
        if (take) begin
            intrpt  = rnd_irq();
            csr_mie = $urandom_range(0, 1) == 1;
            cyc("intr_entry", ITK | PC);
        end
    endtask

    task automatic noise();
        intrpt  = rnd_irq();
        csr_mie = $urandom_range(0, 1) == 1;
    endtask

    logic [6:0] alu_ops [6] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67};
    logic [6:0] bad_ops [4] = '{7'h0F, 7'h00, 7'h7F, 7'h2B};
    logic [2:0] sys_nop [3] = '{3'b010, 3'b100, 3'b110};

    initial begin
        int cls;
        int w;
        int abort_at;
        bit aborted;

        rst = 1'b1; opcode = 7'h00; func = 3'b000; intrpt = 1'b0;
        csr_mie = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        cyc("reset_held", RO);
        rst = 1'b0;
        cyc("init", RO);

        for (int n = 0; n < 400; n++) begin
            // Fetch, with random imem wait and interrupt noise that must be ignored.
            w = $urandom_range(0, 2);
            for (int k = 0; k < w; k++) begin
                imem_ready = 1'b0; noise();
                cyc("fetch_wait", R1);
            end
            imem_ready = 1'b1; noise();
            cyc("fetch", R1);
            imem_ready = $urandom_range(0, 1) == 1;

            cls  = $urandom_range(0, 6);
            func = 3'($urandom_range(0, 7));
            dmem_ready = $urandom_range(0, 1) == 1;
            case (cls)
                0: begin
                    opcode = alu_ops[$urandom_range(0, 5)];
                    retire_cycle("alu", RF | PC | RET);
                end
                1: begin
                    opcode = 7'h63;
                    retire_cycle("branch", PC | RET);
                end
                2: begin
                    opcode = 7'h03; noise();
                    cyc("load_exec", R2);
                    w = $urandom_range(0, 3);
                    for (int k = 0; k < w; k++) begin
                        dmem_ready = 1'b0; noise();
                        cyc("load_wait", R2);
                    end
                    dmem_ready = 1'b1;
                    retire_cycle("load_done", R2 | RF | PC | RET);
                end
                3: begin
                    opcode   = 7'h23;
                    w        = $urandom_range(0, 3);
                    abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, w) : -1;
                    aborted  = 1'b0;
                    for (int k = 0; k < w && !aborted; k++) begin
                        dmem_ready = 1'b0; noise();
                        if (k == abort_at) begin
                            rst = 1'b1;
                            cyc("store_rst", RO);
                            rst = 1'b0;
                            cyc("store_rst_init", RO);
                            aborted = 1'b1;
                        end else begin
                            cyc("store_wait", WE);
                        end
                    end
                    if (!aborted) begin
                        dmem_ready = 1'b1;
                        retire_cycle("store_done", WE | PC | RET);
                    end
                end
                4: begin
                    opcode = 7'h73;
                    func   = {2'($urandom_range(0, 3)), 1'b1};
                    retire_cycle("csrrw", RF | CSR | PC | RET);
                end
                5: begin
                    opcode = 7'h73;
                    func   = 3'b000;
                    retire_cycle("mret", MRT | PC | RET);
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) begin
                        opcode = 7'h73;
                        func   = sys_nop[$urandom_range(0, 2)];
                    end else begin
                        opcode = bad_ops[$urandom_range(0, 3)];
                    end
                    retire_cycle("nop", PC | RET);
                end
            endcase
        end

        // Reset asserted during a fetch wait also returns through INIT.
        imem_ready = 1'b0;
        cyc("tail_fetch", R1);
        rst = 1'b1;
        cyc("tail_rst", RO);
        rst = 1'b0;
        cyc("tail_init", RO);
        imem_ready = 1'b1; intrpt = 1'b1; csr_mie = 1'b1;
        cyc("tail_fetch2", R1);
        opcode = 7'h33;
        cyc("tail_alu_irq", RF | PC | RET);
        intrpt = 1'b0;
        cyc("tail_intr", ITK | PC);
        cyc("tail_fetch3", R1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
